// File: rtl/fetch_decode_buffer.sv
// Circular queue from fetch to decode: compacts masked fetch slots, tags each with its PC, presents oldest DECODE_WIDTH.
// One-cycle minimum latency (no bypass); fetch_ready_out needs room for a full group from registered count only.
module fetch_decode_buffer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int FETCH_WIDTH       = 4,
  parameter int DECODE_WIDTH      = 4,
  parameter int DEPTH             = 16,
  parameter int PC_WIDTH          = 64
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  flush_in,
  input  logic                                  fetch_valid_in,
  input  logic [FETCH_WIDTH-1:0]                fetch_mask_in,
  input  logic [PC_WIDTH-1:0]                   fetch_pc_in,
  input  logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0] fetch_instrs_in,
  output logic                                  fetch_ready_out,
  input  logic                                  decode_ready_in,
  output logic [DECODE_WIDTH-1:0]               decode_valid_out,
  output logic [DECODE_WIDTH*INSTRUCTION_WIDTH-1:0] decode_instrs_out,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0]      decode_pcs_out,
  output logic [$clog2(DEPTH+1)-1:0]            count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]             head, tail;
  logic [CNT_W-1:0]             count;
  logic [INSTRUCTION_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]          pc_mem    [DEPTH];

  logic             enq, deq;
  logic [CNT_W-1:0] mask_pop, enq_n, deq_m;
  logic [PTR_W-1:0] wr_ofs [FETCH_WIDTH];

  assign fetch_ready_out = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign enq             = fetch_valid_in & fetch_ready_out & ~flush_in;
  assign deq             = decode_ready_in & ~flush_in;
  assign count_out       = count;

  // Slot i lands at tail + (number of set mask bits below i).
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_ofs[i] = PTR_W'(mask_pop);
      mask_pop  = mask_pop + CNT_W'(fetch_mask_in[i]);
    end
  end

  always_comb begin
    enq_n = enq ? mask_pop : '0;
    deq_m = '0;
    if (deq) begin
      deq_m = (count > CNT_W'(DECODE_WIDTH)) ? CNT_W'(DECODE_WIDTH) : count;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_m);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - deq_m;
    end
  end

  // Storage needs no reset; occupancy is tracked solely by head/count.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (fetch_mask_in[i]) begin
          instr_mem[tail + wr_ofs[i]] <= fetch_instrs_in[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
          pc_mem[tail + wr_ofs[i]]    <= fetch_pc_in + PC_WIDTH'(4*i);
        end
      end
    end
  end

  always_comb begin
    decode_valid_out  = '0;
    decode_instrs_out = '0;
    decode_pcs_out    = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if ((count > CNT_W'(i)) && !flush_in) begin
        decode_valid_out[i] = 1'b1;
        decode_instrs_out[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = instr_mem[head + PTR_W'(i)];
        decode_pcs_out[i*PC_WIDTH +: PC_WIDTH] = pc_mem[head + PTR_W'(i)];
      end
    end
  end

  a_count_bound: assert property (@(posedge clk_in) disable iff (rst_in) count <= CNT_W'(DEPTH));
  a_no_enq_full: assert property (@(posedge clk_in) disable iff (rst_in) enq |-> fetch_ready_out);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed vector table plus hand sequences and a scoreboarded random stream for fetch_decode_buffer.
module tb_fetch_decode_buffer;

  logic         clk_in = 1'b0;
  logic         rst_in, flush_in, fetch_valid_in, decode_ready_in;
  logic [3:0]   fetch_mask_in;
  logic [63:0]  fetch_pc_in;
  logic [127:0] fetch_instrs_in;
  logic         fetch_ready_out;
  logic [3:0]   decode_valid_out;
  logic [127:0] decode_instrs_out;
  logic [255:0] decode_pcs_out;
  logic [4:0]   count_out;

  fetch_decode_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .fetch_valid_in(fetch_valid_in), .fetch_mask_in(fetch_mask_in),
    .fetch_pc_in(fetch_pc_in), .fetch_instrs_in(fetch_instrs_in),
    .fetch_ready_out(fetch_ready_out), .decode_ready_in(decode_ready_in),
    .decode_valid_out(decode_valid_out), .decode_instrs_out(decode_instrs_out),
    .decode_pcs_out(decode_pcs_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        flush;
    logic        fv;
    logic [3:0]  mask;
    logic [63:0] pc;
    logic        dr;
    logic [4:0]  e_count;
    logic [3:0]  e_valid;
    logic        e_ready;
    logic [63:0] e_pc0;
    logic [63:0] e_pc1;
  } vec_t;

  vec_t        vecs[13];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [63:0] q[$];
  logic [63:0] nxt_pc;
  logic [3:0]  rm, ev;
  int          pushed, cyc, mm;
  bit          acc;

  function automatic logic [31:0] iw(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_F00D;
  endfunction

  function automatic logic [63:0] slot_pc(input int i);
    return decode_pcs_out[i*64 +: 64];
  endfunction

  function automatic logic [31:0] slot_ins(input int i);
    return decode_instrs_out[i*32 +: 32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic set_group(input logic v, input logic [3:0] m, input logic [63:0] pc);
    fetch_valid_in = v;
    fetch_mask_in  = m;
    fetch_pc_in    = pc;
    for (int i = 0; i < 4; i++) fetch_instrs_in[i*32 +: 32] = iw(pc + 64'(4*i));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_flush();
    set_group(1'b0, 4'b0, 64'h0);
    decode_ready_in = 1'b0;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           flush fv    mask     pc                      dr    count valid    rdy   pc0                     pc1
    vecs[0]  = '{1'b0, 1'b0, 4'b0000, 64'h0,                  1'b0, 5'd0, 4'b0000, 1'b1, 64'h0,                  64'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'b1010, 64'h1000,               1'b0, 5'd0, 4'b0000, 1'b1, 64'h0,                  64'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'b0000, 64'h0,                  1'b0, 5'd2, 4'b0011, 1'b1, 64'h1004,               64'h100C};
    vecs[3]  = '{1'b0, 1'b1, 4'b1111, 64'h2000,               1'b1, 5'd2, 4'b0011, 1'b1, 64'h1004,               64'h100C};
    vecs[4]  = '{1'b0, 1'b1, 4'b0101, 64'h3000,               1'b0, 5'd4, 4'b1111, 1'b1, 64'h2000,               64'h2004};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 64'h0,                  1'b1, 5'd6, 4'b1111, 1'b1, 64'h2000,               64'h2004};
    vecs[6]  = '{1'b0, 1'b1, 4'b0000, 64'h4000,               1'b0, 5'd2, 4'b0011, 1'b1, 64'h3000,               64'h3008};
    vecs[7]  = '{1'b1, 1'b1, 4'b1111, 64'h5000,               1'b1, 5'd2, 4'b0000, 1'b1, 64'h0,                  64'h0};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 64'h0,                  1'b0, 5'd0, 4'b0000, 1'b1, 64'h0,                  64'h0};
    vecs[9]  = '{1'b0, 1'b1, 4'b1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5'd0, 4'b0000, 1'b1, 64'h0,                  64'h0};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 64'h0,                  1'b1, 5'd1, 4'b0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[11] = '{1'b0, 1'b1, 4'b0011, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd0, 4'b0000, 1'b1, 64'h0,                  64'h0};
    vecs[12] = '{1'b0, 1'b0, 4'b0000, 64'h0,                  1'b0, 5'd2, 4'b0011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};

    rst_in = 1'b1;
    flush_in = 1'b0;
    decode_ready_in = 1'b0;
    set_group(1'b0, 4'b0, 64'h0);
    repeat (2) tick();
    chk("in_reset_count", count_out, 0);
    chk("in_reset_ready", fetch_ready_out, 1);
    rst_in = 1'b0;

    for (int k = 0; k < 13; k++) begin
      flush_in = vecs[k].flush;
      set_group(vecs[k].fv, vecs[k].mask, vecs[k].pc);
      decode_ready_in = vecs[k].dr;
      #1;
      chk($sformatf("vec%0d_count", k), count_out, vecs[k].e_count);
      chk($sformatf("vec%0d_valid", k), decode_valid_out, vecs[k].e_valid);
      chk($sformatf("vec%0d_ready", k), fetch_ready_out, vecs[k].e_ready);
      chk($sformatf("vec%0d_pc0", k), slot_pc(0), vecs[k].e_pc0);
      chk($sformatf("vec%0d_pc1", k), slot_pc(1), vecs[k].e_pc1);
      chk($sformatf("vec%0d_ins0", k), slot_ins(0), vecs[k].e_valid[0] ? iw(vecs[k].e_pc0) : 32'h0);
      chk($sformatf("vec%0d_ins1", k), slot_ins(1), vecs[k].e_valid[1] ? iw(vecs[k].e_pc1) : 32'h0);
      tick();
    end
    flush_in = 1'b0;
    do_flush();

    // Asynchronous reset in the middle of a cycle with 5 entries held.
    set_group(1'b1, 4'b1111, 64'h7000);
    tick();
    set_group(1'b1, 4'b0001, 64'h7100);
    tick();
    set_group(1'b0, 4'b0, 64'h0);
    #1;
    chk("rst5_before", count_out, 5);
    rst_in = 1'b1;
    #1;
    chk("rst5_async_count", count_out, 0);
    chk("rst5_async_valid", decode_valid_out, 0);
    chk("rst5_async_ready", fetch_ready_out, 1);
    tick();
    rst_in = 1'b0;
    #1;
    chk("rst5_rel_count", count_out, 0);
    tick();
    chk("rst5_later_count", count_out, 0);
    chk("rst5_later_valid", decode_valid_out, 0);

    // Fill to 16, hold a fifth group, then release decode.
    decode_ready_in = 1'b0;
    for (int g = 0; g < 4; g++) begin
      set_group(1'b1, 4'b1111, 64'h100 + 64'(16*g));
      #1;
      chk($sformatf("fill%0d_ready", g), fetch_ready_out, 1);
      chk($sformatf("fill%0d_count", g), count_out, 64'(4*g));
      tick();
    end
    set_group(1'b1, 4'b1111, 64'h140);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("full%0d_count", c), count_out, 16);
      chk($sformatf("full%0d_ready", c), fetch_ready_out, 0);
      tick();
    end
    decode_ready_in = 1'b1;
    #1;
    chk("rel_a_count", count_out, 16);
    chk("rel_a_ready", fetch_ready_out, 0);
    chk("rel_a_pc0", slot_pc(0), 64'h100);
    tick();
    chk("rel_b_count", count_out, 12);
    chk("rel_b_ready", fetch_ready_out, 1);
    chk("rel_b_pc0", slot_pc(0), 64'h110);
    tick();
    set_group(1'b0, 4'b0, 64'h0);
    #1;
    chk("drain_a_count", count_out, 12);
    chk("drain_a_pc0", slot_pc(0), 64'h120);
    tick();
    chk("drain_b_count", count_out, 8);
    chk("drain_b_pc0", slot_pc(0), 64'h130);
    tick();
    chk("drain_c_count", count_out, 4);
    chk("drain_c_pc0", slot_pc(0), 64'h140);
    chk("drain_c_pc3", slot_pc(3), 64'h14C);
    tick();
    chk("drain_d_count", count_out, 0);
    chk("drain_d_valid", decode_valid_out, 0);
    do_flush();

    // Near-full at 14: no credit for same-cycle dequeue, then balanced enq/deq.
    for (int g = 0; g < 3; g++) begin
      set_group(1'b1, 4'b1111, 64'h400 + 64'(16*g));
      tick();
    end
    set_group(1'b1, 4'b0011, 64'h430);
    tick();
    set_group(1'b1, 4'b1111, 64'h600);
    decode_ready_in = 1'b1;
    #1;
    chk("nf_a_count", count_out, 14);
    chk("nf_a_ready", fetch_ready_out, 0);
    tick();
    chk("nf_b_count", count_out, 10);
    chk("nf_b_ready", fetch_ready_out, 1);
    tick();
    chk("nf_c_count", count_out, 10);
    chk("nf_c_pc0", slot_pc(0), 64'h420);
    do_flush();

    // Flush with 9 entries while fetch and decode are both active.
    for (int g = 0; g < 2; g++) begin
      set_group(1'b1, 4'b1111, 64'h800 + 64'(16*g));
      tick();
    end
    set_group(1'b1, 4'b0001, 64'h820);
    tick();
    flush_in = 1'b1;
    set_group(1'b1, 4'b1111, 64'h9000);
    decode_ready_in = 1'b1;
    #1;
    chk("fl_count9", count_out, 9);
    chk("fl_valid", decode_valid_out, 0);
    tick();
    flush_in = 1'b0;
    decode_ready_in = 1'b0;
    set_group(1'b1, 4'b0001, 64'h2000);
    #1;
    chk("fl_after_count", count_out, 0);
    chk("fl_after_valid", decode_valid_out, 0);
    tick();
    set_group(1'b0, 4'b0, 64'h0);
    #1;
    chk("fl_new_count", count_out, 1);
    chk("fl_new_valid", decode_valid_out, 4'b0001);
    chk("fl_new_pc0", slot_pc(0), 64'h2000);
    do_flush();

    // Random stream against a queue model, PCs wrapping through 2^64.
    pushed = 0;
    cyc = 0;
    nxt_pc = 64'hFFFF_FFFF_FFFF_FF00;
    q.delete();
    while ((pushed < 200 || q.size() > 0) && cyc < 3000) begin
      rm = (pushed < 200) ? 4'($urandom_range(0, 15)) : 4'b0;
      set_group(pushed < 200, rm, nxt_pc);
      decode_ready_in = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_count", count_out, 64'(q.size()));
      chk("rnd_ready", fetch_ready_out, (q.size() <= 12) ? 64'h1 : 64'h0);
      for (int i = 0; i < 4; i++) ev[i] = (q.size() > i);
      chk("rnd_valid", decode_valid_out, ev);
      for (int i = 0; i < 4; i++) begin
        if (i < q.size()) begin
          chk($sformatf("rnd_pc%0d", i), slot_pc(i), q[i]);
          chk($sformatf("rnd_ins%0d", i), slot_ins(i), iw(q[i]));
        end
      end
      acc = fetch_valid_in && (q.size() <= 12);
      mm = decode_ready_in ? ((q.size() < 4) ? q.size() : 4) : 0;
      for (int i = 0; i < mm; i++) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          if (rm[i]) begin
            q.push_back(nxt_pc + 64'(4*i));
            pushed++;
          end
        end
        nxt_pc = nxt_pc + 64'd16;
      end
      tick();
      cyc++;
    end
    chk("rnd_completed", (cyc < 3000) ? 64'h1 : 64'h0, 64'h1);
    chk("rnd_final_count", count_out, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
